note_sched_mt: RTL and testbench
================================

Name: note_sched_mt

Overview:
- Parametrised, multi-track successor to the two-track note generator in the rhythm-game core.
- Holds a loadable chart RAM of timestamped note entries. Each entry is an absolute time in ms plus a per-track mask.
- Compares each entry against the free-running game timer and emits one-cycle note pulses on N tracks, with optional lead time.
- Raises a level game-end flag after the final note plus a tail delay. It sits between the ms timer and the per-lane note-fall/judge logic.

Parameters:
- N_TRACKS, 4, number of note lanes (1..8)
- DEPTH, 64, chart entries (power of 2)
- TIME_W, 32, width of timer and entry timestamps (ms)
- LEAD_MS, 0, fire an entry when i_cur_time + LEAD_MS >= entry time (spawn-ahead for fall animation)
- END_DELAY_MS, 2000, tail after last entry time before o_game_end

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_cur_time  in  TIME_W  game time in ms, monotonic non-decreasing while running, may jump by >1 per cycle
- i_start  in  1  one-cycle pulse: (re)start playback from entry 0
- i_chart_len  in  $clog2(DEPTH)+1  number of valid entries, sampled on i_start
- i_wr_en  in  1  chart write strobe
- i_wr_addr  in  $clog2(DEPTH)  chart write address
- i_wr_data  in  TIME_W+N_TRACKS  {time, mask}, mask bit k = track k
- o_note  out  N_TRACKS  one-cycle note pulses, registered
- o_note_idx  out  $clog2(DEPTH)+1  index of entry currently awaited
- o_busy  out  1  high from start until DONE
- o_game_end  out  1  level, high in DONE

Behaviour:
- Reset: state IDLE, o_note=0, o_note_idx=0, o_busy=0, o_game_end=0. Chart RAM contents are not cleared.
- RAM: single write port, synchronous read, 1-cycle read latency. Writes are accepted only in IDLE/DONE; writes in other states are dropped.
- States: IDLE, FETCH, WAIT, DRAIN, DONE.
- IDLE/DONE + i_start: latch len = i_chart_len (clamped to DEPTH), idx=0, o_game_end=0, o_busy=1.
  - If len=0, go to DRAIN with last_time=0.
  - Otherwise go to FETCH.
- FETCH: issue read of idx; go to WAIT next cycle, with the entry registered.
- WAIT: compute due = ({1'b0,i_cur_time} + LEAD_MS) >= {1'b0,entry_time}, evaluated at TIME_W+1 bits so there is no wrap.
  - If due: o_note <= mask on the next edge (pulse exactly 1 cycle); last_time <= entry_time; idx <= idx+1.
  - Then go to FETCH if idx+1 < len, else to DRAIN.
  - If not due: stay in WAIT, o_note=0.
- Throughput: max one entry per 2 cycles. Catch-up after a timer jump fires overdue entries on successive pulses, 2 cycles apart, in index order. No entry is skipped.
- Entries with equal times fire on consecutive pulses. Chords must therefore be encoded as multi-bit masks in one entry.
- Mask=0 entry (rest): advances idx at its time, o_note stays 0.
- DRAIN: when i_cur_time >= last_time + END_DELAY_MS (TIME_W+1 bits), go to DONE; o_game_end=1, o_busy=0.
- DONE: o_game_end held until i_start or rst.
- i_start in FETCH/WAIT/DRAIN: restart immediately. o_note forced 0 that cycle, idx=0, chart_len re-latched, next state FETCH.
- rst mid-play: same as reset, and any pending pulse is suppressed.
- Entries must be in non-decreasing time order. Out-of-order entries fire as soon as reached; no checking is done.

Test Plan (N_TRACKS=4, DEPTH=16, LEAD_MS=0, END_DELAY_MS=100, timer +10 per cycle from 0):
- Load {100,0001},{200,0110},{300,1000}, len=3, start.
  - Required: o_note=0001 exactly one cycle after time 100 is seen, 0110 after 200, 1000 after 300.
  - Required: o_game_end rises once time>=400 and stays high; o_busy falls in the same cycle.
- Timer jumps 0→1000 in one cycle with the same chart.
  - Required: three pulses 0001, 0110, 1000 on cycles t+1, t+3, t+5.
  - Required: o_note_idx steps 0→1→2→3.
- Rest and equal times: {50,0000},{50,0010},{50,0100}.
  - Required: no pulse for entry 0; pulses 0010 then 0100 two cycles apart; idx reaches 3.
- Restart: i_start asserted while idx=1 (waiting for 200) and time=150.
  - Required: o_note=0 that cycle; entry 0 (time 100) fires again within 3 cycles since it is due.
  - Required: o_game_end stays 0.
- len=0 start at time 0.
  - Required: no pulses; o_game_end=1 once time>=100.
  - Writes during play are ignored: rewriting addr 2 with {300,0001} mid-play still yields 1000 at time 300.
- Sync reset at time 150 with LEAD_MS=50 build: o_note, o_busy, o_game_end all 0 next cycle.
  - Required: after a fresh start, entry {100,0001} fires when time>=50.

Source files
------------

// File: rtl/note_sched_mt.sv
// note_sched_mt
//   Multi-track chart scheduler for the rhythm-game core. A chart RAM holds
//   timestamped entries {time_ms, track_mask}, sorted by time. Playback walks
//   the chart in index order. Each entry is compared against the free-running
//   ms timer, and when it becomes due the entry emits a one-cycle pulse on the
//   tracks in its mask. A level game-end flag rises END_DELAY_MS after the
//   last entry's time.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   i_cur_time   game time in ms (non-decreasing while playing, may jump)
//   i_start      one-cycle pulse: (re)start playback from entry 0
//   i_chart_len  number of valid entries, sampled with i_start
//   i_wr_en      chart write strobe (accepted only while IDLE or DONE)
//   i_wr_addr    chart write address
//   i_wr_data    {time, mask}; mask bit k drives track k
//   o_note       registered one-cycle note pulses, one bit per track
//   o_note_idx   index of the entry currently awaited
//   o_busy       high from start until DONE
//   o_game_end   level, high while in DONE
//   o_state      current FSM state, for debug and checker binding
//
// Control strobes: i_start and i_wr_en are single-cycle qualifiers with no
// back-pressure. They are sampled on every rising clk edge, and the block
// never stalls the producer. i_start takes priority over everything except
// rst. A write strobe outside IDLE/DONE is silently dropped.

module note_sched_mt #(
    parameter int N_TRACKS     = 4,
    parameter int DEPTH        = 64,
    parameter int TIME_W       = 32,
    parameter int LEAD_MS      = 0,
    parameter int END_DELAY_MS = 2000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TIME_W-1:0]            i_cur_time,
    input  logic                         i_start,
    input  logic [$clog2(DEPTH):0]       i_chart_len,
    input  logic                         i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
    input  logic [TIME_W+N_TRACKS-1:0]   i_wr_data,
    output logic [N_TRACKS-1:0]          o_note,
    output logic [$clog2(DEPTH):0]       o_note_idx,
    output logic                         o_busy,
    output logic                         o_game_end,
    output logic [2:0]                   o_state
);

    localparam int AW = $clog2(DEPTH);

    // Timer comparisons run one bit wider than the timer so that adding the
    // lead or tail delay can never wrap past zero.
    localparam logic [TIME_W:0] LEAD_EXT  = (TIME_W+1)'(LEAD_MS);
    localparam logic [TIME_W:0] END_EXT   = (TIME_W+1)'(END_DELAY_MS);
    localparam logic [AW:0]     DEPTH_LEN = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      state;
    logic [TIME_W+N_TRACKS-1:0]  mem [DEPTH];
    logic [TIME_W-1:0]           entry_time;
    logic [N_TRACKS-1:0]         entry_mask;
    logic [TIME_W-1:0]           last_time;
    logic [AW:0]                 idx;
    logic [AW:0]                 len;

    logic [TIME_W:0]             cur_ext;
    logic                        due;
    logic                        drained;
    logic [AW:0]                 len_clamped;
    logic [AW:0]                 idx_inc;
    logic                        wr_ok;

    always_comb begin
        cur_ext     = {1'b0, i_cur_time};
        due         = (cur_ext + LEAD_EXT) >= {1'b0, entry_time};
        drained     = cur_ext >= ({1'b0, last_time} + END_EXT);
        len_clamped = (i_chart_len > DEPTH_LEN) ? DEPTH_LEN : i_chart_len;
        idx_inc     = idx + (AW+1)'(1);
        wr_ok       = (state == S_IDLE) || (state == S_DONE);
    end

    // Chart RAM write port. Contents survive reset on purpose: a chart can be
    // loaded once and replayed across resets.
    always_ff @(posedge clk) begin
        if (i_wr_en && wr_ok) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            o_note     <= '0;
            o_busy     <= 1'b0;
            o_game_end <= 1'b0;
            idx        <= '0;
            len        <= '0;
            last_time  <= '0;
            entry_time <= '0;
            entry_mask <= '0;
        end else begin
            // Pulses last exactly one cycle: only a due entry in WAIT
            // overrides this default.
            o_note <= '0;

            if (i_start) begin
                // Restart from any state. An empty chart goes directly to
                // DRAIN, so it never fetches and fires a stale entry 0.
                len        <= len_clamped;
                idx        <= '0;
                o_game_end <= 1'b0;
                o_busy     <= 1'b1;
                if (len_clamped == '0) begin
                    last_time <= '0;
                    state     <= S_DRAIN;
                end else begin
                    state <= S_FETCH;
                end
            end else begin
                case (state)
                    S_FETCH: begin
                        // Synchronous read. The entry is registered and is
                        // valid in WAIT.
                        {entry_time, entry_mask} <= mem[idx[AW-1:0]];
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (due) begin
                            o_note    <= entry_mask;
                            last_time <= entry_time;
                            idx       <= idx_inc;
                            state     <= (idx_inc < len) ? S_FETCH : S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (drained) begin
                            o_game_end <= 1'b1;
                            o_busy     <= 1'b0;
                            state      <= S_DONE;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until the next start.
                    end
                endcase
            end
        end
    end

    assign o_note_idx = idx;
    assign o_state    = state;

endmodule

// File: tb/tb_note_sched_mt.sv
// tb_note_sched_mt
//   Directed bench for note_sched_mt (N_TRACKS=4, DEPTH=16, END_DELAY_MS=100).
//   dut runs with LEAD_MS=0. dut_l shares every input and runs with
//   LEAD_MS=50. The timer normally advances 10 ms per cycle. Expected note
//   times are listed per phase in a small event table.

module tb_note_sched_mt;

    localparam int N_TRACKS = 4;
    localparam int DEPTH    = 16;
    localparam int TIME_W   = 32;
    localparam int AW       = $clog2(DEPTH);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst;
    logic [TIME_W-1:0]           cur_time;
    logic                        start;
    logic [AW:0]                 chart_len;
    logic                        wr_en;
    logic [AW-1:0]               wr_addr;
    logic [TIME_W+N_TRACKS-1:0]  wr_data;

    logic [N_TRACKS-1:0]         note,   note_l;
    logic [AW:0]                 idx,    idx_l;
    logic                        busy,   busy_l;
    logic                        gend,   gend_l;
    logic [2:0]                  st,     st_l;

    note_sched_mt #(.N_TRACKS(N_TRACKS), .DEPTH(DEPTH), .TIME_W(TIME_W),
                    .LEAD_MS(0), .END_DELAY_MS(100)) dut (
        .clk(clk), .rst(rst), .i_cur_time(cur_time), .i_start(start),
        .i_chart_len(chart_len), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_note(note), .o_note_idx(idx),
        .o_busy(busy), .o_game_end(gend), .o_state(st)
    );

    note_sched_mt #(.N_TRACKS(N_TRACKS), .DEPTH(DEPTH), .TIME_W(TIME_W),
                    .LEAD_MS(50), .END_DELAY_MS(100)) dut_l (
        .clk(clk), .rst(rst), .i_cur_time(cur_time), .i_start(start),
        .i_chart_len(chart_len), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_note(note_l), .o_note_idx(idx_l),
        .o_busy(busy_l), .o_game_end(gend_l), .o_state(st_l)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    // Expected pulses for the current phase: ev_t[i] ms -> ev_m[i] mask.
    int         ev_t [3];
    logic [3:0] ev_m [3];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Outputs are sampled 1 time unit after the edge that consumed the inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int t, input logic [3:0] m);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = {TIME_W'(t), m};
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_base();
        wr(0, 100, 4'b0001);
        wr(1, 200, 4'b0110);
        wr(2, 300, 4'b1000);
    endtask

    task automatic do_start(input int len, input int t);
        chart_len = (AW+1)'(len);
        cur_time  = TIME_W'(t);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic set_ev(input int t0, input logic [3:0] m0,
                          input int t1, input logic [3:0] m1,
                          input int t2, input logic [3:0] m2);
        ev_t[0] = t0; ev_m[0] = m0;
        ev_t[1] = t1; ev_m[1] = m1;
        ev_t[2] = t2; ev_m[2] = m2;
    endtask

    // Advance the timer 10 ms per cycle from t_from to t_to. On each cycle,
    // check dut's pulse, game-end and busy against the event table and the
    // game-end time.
    task automatic run_clock(input int t_from, input int t_to, input int end_t);
        logic [3:0] exp_note;
        for (int t = t_from; t <= t_to; t += 10) begin
            cur_time = TIME_W'(t);
            tick();
            exp_note = 4'b0000;
            for (int i = 0; i < 3; i++) begin
                if (ev_t[i] == t) exp_note = ev_m[i];
            end
            check($sformatf("note t=%0d", t), 64'(note), 64'(exp_note));
            check($sformatf("game_end t=%0d", t), 64'(gend), 64'(t >= end_t));
            check($sformatf("busy t=%0d", t), 64'(busy), 64'(t < end_t));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; cur_time = '0; start = 1'b0; chart_len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        set_ev(-1, 4'h0, -1, 4'h0, -1, 4'h0);
        tick();
        tick();
        check("reset note",  64'(note), 64'd0);
        check("reset idx",   64'(idx),  64'd0);
        check("reset busy",  64'(busy), 64'd0);
        check("reset gend",  64'(gend), 64'd0);
        check("reset state", 64'(st),   64'd0);
        rst = 1'b0;

        // 1: basic playback, notes at 100/200/300, game end at 400
        load_base();
        do_start(3, 0);
        check("start busy",  64'(busy), 64'd1);
        check("start state", 64'(st),   64'd1);
        set_ev(100, 4'b0001, 200, 4'b0110, 300, 4'b1000);
        run_clock(10, 450, 400);
        check("p1 done state", 64'(st), 64'd4);

        // 2: timer jumps 0 -> 1000, catch-up pulses two cycles apart
        do_start(3, 0);
        tick();  // FETCH -> WAIT
        tick();  // WAIT, entry 0 not yet due
        check("jump pre note", 64'(note), 64'd0);
        check("jump pre idx",  64'(idx),  64'd0);
        cur_time = 1000;
        tick(); check("jump n1", 64'(note), 64'b0001); check("jump i1", 64'(idx), 64'd1);
        tick(); check("jump n2", 64'(note), 64'b0000); check("jump i2", 64'(idx), 64'd1);
        tick(); check("jump n3", 64'(note), 64'b0110); check("jump i3", 64'(idx), 64'd2);
        tick(); check("jump n4", 64'(note), 64'b0000); check("jump i4", 64'(idx), 64'd2);
        tick(); check("jump n5", 64'(note), 64'b1000); check("jump i5", 64'(idx), 64'd3);
        tick(); check("jump gend", 64'(gend), 64'd1); check("jump busy", 64'(busy), 64'd0);

        // 3: rest entry plus equal timestamps
        wr(0, 50, 4'b0000);
        wr(1, 50, 4'b0010);
        wr(2, 50, 4'b0100);
        do_start(3, 0);
        set_ev(70, 4'b0010, 90, 4'b0100, -1, 4'h0);
        run_clock(10, 50, 150);
        check("rest idx", 64'(idx), 64'd1);
        run_clock(60, 160, 150);
        check("equal idx", 64'(idx), 64'd3);

        // 4: restart while waiting for entry 1 at time 150
        load_base();
        do_start(3, 0);
        set_ev(100, 4'b0001, -1, 4'h0, -1, 4'h0);
        run_clock(10, 140, 99999);
        check("pre-restart idx", 64'(idx), 64'd1);
        do_start(3, 150);
        check("restart note", 64'(note), 64'd0);
        check("restart idx",  64'(idx),  64'd0);
        check("restart gend", 64'(gend), 64'd0);
        set_ev(170, 4'b0001, 200, 4'b0110, 300, 4'b1000);
        run_clock(160, 410, 400);

        // 5: empty chart, game end after the tail only
        do_start(0, 0);
        check("len0 busy",  64'(busy), 64'd1);
        check("len0 state", 64'(st),   64'd3);
        set_ev(-1, 4'h0, -1, 4'h0, -1, 4'h0);
        run_clock(10, 110, 100);

        // 5b: a write during play is dropped
        do_start(3, 0);
        set_ev(100, 4'b0001, -1, 4'h0, -1, 4'h0);
        run_clock(10, 140, 99999);
        wr_en = 1'b1; wr_addr = 2; wr_data = {TIME_W'(300), 4'b0001};
        set_ev(-1, 4'h0, -1, 4'h0, -1, 4'h0);
        run_clock(150, 150, 99999);
        wr_en = 1'b0;
        set_ev(200, 4'b0110, 300, 4'b1000, -1, 4'h0);
        run_clock(160, 410, 400);

        // 6: reset mid-play suppresses the pending pulse of the LEAD_MS=50 unit
        do_start(3, 0);
        set_ev(100, 4'b0001, -1, 4'h0, -1, 4'h0);
        run_clock(10, 140, 99999);
        check("lead busy",    64'(busy_l), 64'd1);
        check("lead pre idx", 64'(idx_l),  64'd1);
        cur_time = 150;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst lead note",  64'(note_l), 64'd0);
        check("rst lead busy",  64'(busy_l), 64'd0);
        check("rst lead gend",  64'(gend_l), 64'd0);
        check("rst lead idx",   64'(idx_l),  64'd0);
        check("rst lead state", 64'(st_l),   64'd0);
        check("rst note",       64'(note),   64'd0);
        check("rst busy",       64'(busy),   64'd0);
        do_start(3, 0);
        for (int t = 10; t <= 40; t += 10) begin
            cur_time = TIME_W'(t);
            tick();
            check($sformatf("lead early t=%0d", t), 64'(note_l), 64'd0);
        end
        cur_time = 50;
        tick();
        check("lead fire note", 64'(note_l), 64'b0001);
        check("lead fire idx",  64'(idx_l),  64'd1);
        check("nolead at 50",   64'(note),   64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
